// File: rtl/postbox_lcd_writer.sv
// postbox_lcd_writer
// Takes completed bytes (data + register select) from the POST-port command
// decoder and writes them to an HD44780 LCD in 4-bit mode. After reset it
// waits for the controller's power-on delay and issues the 4-bit init
// nibbles (0x3, 0x3, 0x3, 0x2). After that it accepts one byte at a time
// and sends it as two E-strobed nibbles, high nibble first. All delays are
// counted in refclk cycles.
//
// Ports:
//   refclk    in   system clock, all logic on the rising edge
//   reset     in   synchronous active-high reset
//   in_data   in   [7:0] byte to write
//   in_rs     in   register select for in_data (0 = command, 1 = data)
//   in_valid  in   in_data/in_rs valid
//   in_ready  out  byte accepted this cycle if in_valid is high (IDLE only)
//   lcd_data  out  [3:0] LCD DB7..DB4
//   lcd_rs    out  LCD RS
//   lcd_e     out  LCD E strobe
//   init_done out  power-on init complete, sticky until reset

module postbox_lcd_writer #(
   parameter int T_SETUP   = 2,
   parameter int T_EPW     = 6,
   parameter int T_HOLD    = 2,
   parameter int T_CMD     = 480,
   parameter int T_SLOW    = 19680,
   parameter int T_POWERON = 180000,
   parameter int T_INIT    = 49200
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_rs,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic       init_done
);

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared down-counter, wide enough for the longest delay.
   localparam int MAXP = maxOf(maxOf(maxOf(T_SETUP, T_EPW), maxOf(T_HOLD, T_CMD)),
                               maxOf(maxOf(T_SLOW, T_POWERON), T_INIT));
   localparam int CW   = $clog2(MAXP + 1);

   // The init nibbles reuse the SETUP/E_HIGH/HOLD strobe states. initDone_q
   // decides where HOLD goes next: INIT_GAP while initialising, otherwise
   // the second nibble of the byte or GAP.
   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_GAP,
      IDLE,
      SETUP,
      E_HIGH,
      HOLD,
      GAP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            nibHi_q, nibHi_d;
   logic [1:0]      initIdx_q, initIdx_d;
   logic [3:0]      lcdData_q, lcdData_d;
   logic            lcdRs_q, lcdRs_d;
   logic [7:0]      byteData_q, byteData_d;
   logic            byteRs_q, byteRs_d;
   logic            initDone_q, initDone_d;
   logic            cntZero;
   logic            slowCmd;

   assign cntZero = (cnt_q == '0);

   // Clear display (0x01) and return home (0x02/0x03) need the long execution gap.
   assign slowCmd = !byteRs_q && (byteData_q == 8'h01 || byteData_q == 8'h02 ||
                                  byteData_q == 8'h03);

   // Register stage. Reset starts the full power-on wait. The counter is
   // loaded with T_POWERON so that the first init nibble is driven on edge
   // T_POWERON, counting the first edge with reset low as edge 0.
   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q    <= PWR_WAIT;
         cnt_q      <= CW'(T_POWERON);
         nibHi_q    <= 1'b0;
         initIdx_q  <= 2'd0;
         lcdData_q  <= 4'h0;
         lcdRs_q    <= 1'b0;
         byteData_q <= 8'h00;
         byteRs_q   <= 1'b0;
         initDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         nibHi_q    <= nibHi_d;
         initIdx_q  <= initIdx_d;
         lcdData_q  <= lcdData_d;
         lcdRs_q    <= lcdRs_d;
         byteData_q <= byteData_d;
         byteRs_q   <= byteRs_d;
         initDone_q <= initDone_d;
      end
   end

   // Next-state logic. Every timed state loads the counter with (delay - 1)
   // on entry and leaves on the cycle it reads zero, so it lasts exactly
   // 'delay' cycles. lcd_data/lcd_rs change only when a new nibble starts,
   // so they stay put through E high, hold, GAP and IDLE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nibHi_d    = nibHi_q;
      initIdx_d  = initIdx_q;
      lcdData_d  = lcdData_q;
      lcdRs_d    = lcdRs_q;
      byteData_d = byteData_q;
      byteRs_d   = byteRs_q;
      initDone_d = initDone_q;

      case (state_q)
         PWR_WAIT: begin
            if (cntZero) begin
               state_d   = SETUP;
               cnt_d     = CW'(T_SETUP - 1);
               initIdx_d = 2'd0;
               lcdData_d = 4'h3;
               lcdRs_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         INIT_GAP: begin
            if (cntZero) begin
               if (initIdx_q == 2'd3) begin
                  state_d    = IDLE;
                  initDone_d = 1'b1;
               end else begin
                  state_d   = SETUP;
                  cnt_d     = CW'(T_SETUP - 1);
                  initIdx_d = initIdx_q + 2'd1;
                  lcdData_d = (initIdx_q == 2'd2) ? 4'h2 : 4'h3;
                  lcdRs_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         IDLE: begin
            if (in_valid) begin
               state_d    = SETUP;
               cnt_d      = CW'(T_SETUP - 1);
               byteData_d = in_data;
               byteRs_d   = in_rs;
               lcdData_d  = in_data[7:4];
               lcdRs_d    = in_rs;
               nibHi_d    = 1'b1;
            end
         end

         SETUP: begin
            if (cntZero) begin
               state_d = E_HIGH;
               cnt_d   = CW'(T_EPW - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         E_HIGH: begin
            if (cntZero) begin
               state_d = HOLD;
               cnt_d   = CW'(T_HOLD - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         HOLD: begin
            if (cntZero) begin
               if (!initDone_q) begin
                  // The first init nibble needs the long 4.1 ms settle time.
                  state_d = INIT_GAP;
                  cnt_d   = (initIdx_q == 2'd0) ? CW'(T_INIT - 1) : CW'(T_CMD - 1);
               end else if (nibHi_q) begin
                  state_d   = SETUP;
                  cnt_d     = CW'(T_SETUP - 1);
                  lcdData_d = byteData_q[3:0];
                  nibHi_d   = 1'b0;
               end else begin
                  state_d = GAP;
                  cnt_d   = slowCmd ? CW'(T_SLOW - 1) : CW'(T_CMD - 1);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         GAP: begin
            if (cntZero) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = PWR_WAIT;
            cnt_d   = CW'(T_POWERON);
         end
      endcase
   end

   // E and ready come straight from the state register. Because of this,
   // both are low in every state where they must be, including the reset state.
   assign in_ready  = (state_q == IDLE);
   assign lcd_e     = (state_q == E_HIGH);
   assign lcd_data  = lcdData_q;
   assign lcd_rs    = lcdRs_q;
   assign init_done = initDone_q;

endmodule

// File: tb/tb_postbox_lcd_writer.sv
// tb_postbox_lcd_writer
// Self-checking bench for postbox_lcd_writer using short delays. A sampler
// records every DUT output once per cycle on the falling edge. Each test
// drives its stimulus, extracts E strobes and ready/done rises from that
// record, and compares them with timings computed from the writer's rules:
// nibble order, setup/pulse/hold lengths and gap selection.

module tb_postbox_lcd_writer;

   localparam int T_SETUP   = 1;
   localparam int T_EPW     = 3;
   localparam int T_HOLD    = 1;
   localparam int T_CMD     = 10;
   localparam int T_SLOW    = 50;
   localparam int T_POWERON = 100;
   localparam int T_INIT    = 30;
   localparam int N         = T_SETUP + T_EPW + T_HOLD;
   localparam int LIMIT     = 1000;

   logic       refclk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_rs;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_e;
   logic       init_done;

   int vectors;
   int miscompares;
   int edgeCount;

   typedef struct {
      int         c;
      logic [3:0] d;
      logic       rs;
      logic       e;
      logic       rdy;
      logic       done;
   } samp_t;

   typedef struct {
      int         c;
      logic [3:0] d;
      logic       rs;
      int         w;
      bit         stable;
   } strobe_t;

   samp_t      trace[$];
   strobe_t    strobes[$];
   int         readyRises[$];
   int         doneRises[$];
   logic [7:0] qData[$];
   logic       qRs[$];
   int         qAcc[$];

   postbox_lcd_writer #(
      .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD), .T_CMD(T_CMD),
      .T_SLOW(T_SLOW), .T_POWERON(T_POWERON), .T_INIT(T_INIT)
   ) dut (
      .refclk(refclk),
      .reset(reset),
      .in_data(in_data),
      .in_rs(in_rs),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .lcd_data(lcd_data),
      .lcd_rs(lcd_rs),
      .lcd_e(lcd_e),
      .init_done(init_done)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   // Edge counter: the first rising edge with reset low is cycle 0.
   always @(posedge refclk) begin
      if (reset) edgeCount <= 0;
      else       edgeCount <= edgeCount + 1;
   end

   // Sample all outputs once per cycle, away from the active edge.
   always @(negedge refclk) begin
      samp_t s;
      s.c    = edgeCount - 1;
      s.d    = lcd_data;
      s.rs   = lcd_rs;
      s.e    = lcd_e;
      s.rdy  = in_ready;
      s.done = init_done;
      trace.push_back(s);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time expired, required completion before limit");
      $fatal(1, "[TB] watchdog");
   end

   // Reference rule: clear/home commands get the slow gap, everything else the normal one.
   function automatic int gapFor(input logic [7:0] d, input logic r);
      return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? T_SLOW : T_CMD;
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic waitReady(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < LIMIT; k++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge refclk);
      end
   endtask

   task automatic waitInitDone(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < LIMIT; k++) begin
         if (init_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge refclk);
      end
   endtask

   // Offer one byte and hold it until accepted. acc is the cycle in which
   // in_valid and in_ready were both high.
   task automatic sendByte(input logic [7:0] d, input logic r, output int acc, output bit ok);
      in_data  = d;
      in_rs    = r;
      in_valid = 1'b1;
      ok       = 1'b0;
      acc      = -1;
      for (int k = 0; k < LIMIT; k++) begin
         if (in_ready === 1'b1) begin
            acc = edgeCount - 1;
            ok  = 1'b1;
            break;
         end
         @(negedge refclk);
      end
      @(negedge refclk);
      in_valid = 1'b0;
   endtask

   // Turn the sample record into E strobes (rise cycle, nibble, RS, width,
   // and whether data/RS stayed constant from setup through hold) and
   // rising edges of in_ready/init_done.
   task automatic extractTrace();
      strobes.delete();
      readyRises.delete();
      doneRises.delete();
      for (int i = 1; i < trace.size(); i++) begin
         if (trace[i].e === 1'b1 && trace[i-1].e !== 1'b1) begin
            strobe_t s;
            s.c = trace[i].c;
            s.d = trace[i].d;
            s.rs = trace[i].rs;
            s.w = 0;
            s.stable = 1'b1;
            for (int j = i; j < trace.size() && trace[j].e === 1'b1; j++) s.w++;
            for (int j = i - T_SETUP; j <= i + s.w + T_HOLD - 1; j++)
               if (j >= 0 && j < trace.size())
                  if (trace[j].d !== s.d || trace[j].rs !== s.rs) s.stable = 1'b0;
            strobes.push_back(s);
         end
         if (trace[i].rdy === 1'b1 && trace[i-1].rdy !== 1'b1) readyRises.push_back(trace[i].c);
         if (trace[i].done === 1'b1 && trace[i-1].done !== 1'b1) doneRises.push_back(trace[i].c);
      end
   endtask

   // Send every byte in qData/qRs one at a time and record the accept cycles.
   task automatic applyStimulus();
      bit ok;
      int acc;
      trace.delete();
      qAcc.delete();
      for (int i = 0; i < qData.size(); i++) begin
         sendByte(qData[i], qRs[i], acc, ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL accept_timeout byte%0d: got no accept, required accept within %0d cycles", i, LIMIT);
         end
         qAcc.push_back(acc);
      end
      waitReady(ok);
      waitCycles(3);
      extractTrace();
   endtask

   task automatic test_reset();
      bit ok;
      int bad;
      int start;
      int expDone;
      int gaps[4];
      logic [3:0] nib[4];
      gaps = '{T_INIT, T_CMD, T_CMD, T_CMD};
      nib  = '{4'h3, 4'h3, 4'h3, 4'h2};
      reset = 1'b1;
      in_valid = 1'b0;
      waitCycles(3);
      vectors++;
      if ({lcd_data, lcd_rs, lcd_e, in_ready, init_done} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_state: got %h, required 00", {lcd_data, lcd_rs, lcd_e, in_ready, init_done});
      end
      trace.delete();
      reset = 1'b0;
      waitInitDone(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL init_timeout: got init_done=%b, required 1", init_done);
      end
      waitCycles(5);
      extractTrace();
      bad = 0;
      foreach (trace[i])
         if (trace[i].c >= 0 && trace[i].c < T_POWERON &&
             {trace[i].d, trace[i].rs, trace[i].e, trace[i].rdy, trace[i].done} !== 8'h00) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL poweron_quiet: got %0d nonzero cycles, required 0", bad);
      end
      vectors++;
      if (strobes.size() != 4) begin
         miscompares++;
         $display("FAIL init_strobe_count: got %0d, required 4", strobes.size());
      end
      start = T_POWERON;
      for (int k = 0; k < 4 && k < strobes.size(); k++) begin
         vectors++;
         if (strobes[k].d !== nib[k] || strobes[k].rs !== 1'b0 || strobes[k].c != start + T_SETUP ||
             strobes[k].w != T_EPW || !strobes[k].stable) begin
            miscompares++;
            $display("FAIL init_nib%0d: got d=%h rs=%b rise=%0d w=%0d stable=%0b, required d=%h rs=0 rise=%0d w=%0d stable=1",
                     k, strobes[k].d, strobes[k].rs, strobes[k].c, strobes[k].w, strobes[k].stable,
                     nib[k], start + T_SETUP, T_EPW);
         end
         start += N + gaps[k];
      end
      expDone = T_POWERON + 4 * N + T_INIT + 3 * T_CMD;
      vectors++;
      if (readyRises.size() < 1 || readyRises[0] != expDone || doneRises.size() < 1 || doneRises[0] != expDone) begin
         miscompares++;
         $display("FAIL init_done_time: got ready=%0d done=%0d, required %0d",
                  readyRises.size() > 0 ? readyRises[0] : -1, doneRises.size() > 0 ? doneRises[0] : -1, expDone);
      end
   endtask

   task automatic test_data_byte();
      qData.delete();
      qRs.delete();
      qData.push_back(8'hA8);
      qRs.push_back(1'b1);
      for (int i = 0; i < 4; i++) begin
         qData.push_back(8'($urandom_range(0, 255)));
         qRs.push_back(1'($urandom_range(0, 1)));
      end
      applyStimulus();
      vectors++;
      if (strobes.size() != 2 * qData.size()) begin
         miscompares++;
         $display("FAIL data_strobe_count: got %0d, required %0d", strobes.size(), 2 * qData.size());
      end
      for (int i = 0; i < qData.size(); i++) begin
         int a = qAcc[i];
         for (int h = 0; h < 2; h++) begin
            int k = 2 * i + h;
            logic [3:0] en = (h == 0) ? qData[i][7:4] : qData[i][3:0];
            vectors++;
            if (k >= strobes.size()) begin
               miscompares++;
               $display("FAIL data_byte%0d_nib%0d: got no strobe, required d=%h", i, h, en);
            end else if (strobes[k].d !== en || strobes[k].rs !== qRs[i] || strobes[k].c != a + 1 + h * N + T_SETUP ||
                         strobes[k].w != T_EPW || !strobes[k].stable) begin
               miscompares++;
               $display("FAIL data_byte%0d_nib%0d: got d=%h rs=%b rise=%0d w=%0d stable=%0b, required d=%h rs=%b rise=%0d w=%0d stable=1",
                        i, h, strobes[k].d, strobes[k].rs, strobes[k].c, strobes[k].w, strobes[k].stable,
                        en, qRs[i], a + 1 + h * N + T_SETUP, T_EPW);
            end
         end
         vectors++;
         if (i >= readyRises.size() || readyRises[i] != a + 1 + 2 * N + gapFor(qData[i], qRs[i])) begin
            miscompares++;
            $display("FAIL data_ready%0d: got %0d, required %0d", i,
                     i < readyRises.size() ? readyRises[i] : -1, a + 1 + 2 * N + gapFor(qData[i], qRs[i]));
         end
      end
      vectors++;
      if (readyRises.size() < 1 || readyRises[0] - qAcc[0] != 21) begin
         miscompares++;
         $display("FAIL data_a8_ready_offset: got %0d, required 21",
                  readyRises.size() > 0 ? readyRises[0] - qAcc[0] : -1);
      end
   endtask

   task automatic test_clear_cmd();
      int expOff[3];
      expOff = '{61, 21, 21};
      qData.delete();
      qRs.delete();
      qData.push_back(8'h01); qRs.push_back(1'b0);
      qData.push_back(8'h04); qRs.push_back(1'b0);
      qData.push_back(8'h01); qRs.push_back(1'b1);
      qData.push_back(8'h02); qRs.push_back(1'b0);
      qData.push_back(8'h03); qRs.push_back(1'b0);
      applyStimulus();
      vectors++;
      if (strobes.size() != 2 * qData.size()) begin
         miscompares++;
         $display("FAIL clear_strobe_count: got %0d, required %0d", strobes.size(), 2 * qData.size());
      end
      for (int i = 0; i < qData.size(); i++) begin
         int a = qAcc[i];
         int k = 2 * i;
         vectors++;
         if (k + 1 >= strobes.size() || strobes[k].d !== qData[i][7:4] || strobes[k+1].d !== qData[i][3:0] ||
             strobes[k].rs !== qRs[i] || strobes[k+1].rs !== qRs[i]) begin
            miscompares++;
            $display("FAIL clear_nibbles%0d: got %h/%h, required %h/%h", i,
                     k < strobes.size() ? strobes[k].d : 4'hx, k + 1 < strobes.size() ? strobes[k+1].d : 4'hx,
                     qData[i][7:4], qData[i][3:0]);
         end
         vectors++;
         if (i >= readyRises.size() || readyRises[i] != a + 1 + 2 * N + gapFor(qData[i], qRs[i])) begin
            miscompares++;
            $display("FAIL clear_ready%0d: got %0d, required %0d", i,
                     i < readyRises.size() ? readyRises[i] : -1, a + 1 + 2 * N + gapFor(qData[i], qRs[i]));
         end
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (i >= readyRises.size() || readyRises[i] - qAcc[i] != expOff[i]) begin
            miscompares++;
            $display("FAIL clear_offset%0d: got %0d, required %0d", i,
                     i < readyRises.size() ? readyRises[i] - qAcc[i] : -1, expOff[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int startCyc;
      logic [7:0] bd[3];
      int acc[3];
      foreach (bd[i]) bd[i] = 8'($urandom_range(0, 255));
      trace.delete();
      startCyc = edgeCount - 1;
      in_data  = bd[0];
      in_rs    = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         acc[i] = -1;
         for (int k = 0; k < LIMIT; k++) begin
            if (in_ready === 1'b1) begin
               acc[i] = edgeCount - 1;
               break;
            end
            @(negedge refclk);
         end
         @(negedge refclk);
         if (i < 2) in_data = bd[i+1];
         else       in_valid = 1'b0;
      end
      waitReady(ok);
      waitCycles(3);
      extractTrace();
      vectors++;
      if (acc[0] != startCyc) begin
         miscompares++;
         $display("FAIL b2b_accept0: got %0d, required %0d", acc[0], startCyc);
      end
      for (int i = 1; i < 3; i++) begin
         vectors++;
         if (acc[i] != acc[i-1] + 1 + 2 * N + T_CMD) begin
            miscompares++;
            $display("FAIL b2b_accept%0d: got %0d, required %0d", i, acc[i], acc[i-1] + 1 + 2 * N + T_CMD);
         end
      end
      vectors++;
      if (strobes.size() != 6) begin
         miscompares++;
         $display("FAIL b2b_strobe_count: got %0d, required 6", strobes.size());
      end
      for (int k = 0; k < 6 && k < strobes.size(); k++) begin
         logic [3:0] en = (k % 2 == 0) ? bd[k/2][7:4] : bd[k/2][3:0];
         vectors++;
         if (strobes[k].d !== en || strobes[k].rs !== 1'b1 || strobes[k].w != T_EPW || !strobes[k].stable) begin
            miscompares++;
            $display("FAIL b2b_strobe%0d: got d=%h rs=%b w=%0d stable=%0b, required d=%h rs=1 w=%0d stable=1",
                     k, strobes[k].d, strobes[k].rs, strobes[k].w, strobes[k].stable, en, T_EPW);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit sawE;
      int acc;
      int expDone;
      logic [3:0] nib[4];
      nib = '{4'h3, 4'h3, 4'h3, 4'h2};
      sendByte(8'h5C, 1'b1, acc, ok);
      sawE = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (lcd_e === 1'b1) begin
            sawE = 1'b1;
            break;
         end
         @(negedge refclk);
      end
      vectors++;
      if (!ok || !sawE || lcd_data !== 4'h5) begin
         miscompares++;
         $display("FAIL midreset_setup: got accept=%0b e=%0b d=%h, required accept=1 e=1 d=5", ok, sawE, lcd_data);
      end
      reset = 1'b1;
      @(negedge refclk);
      vectors++;
      if ({lcd_data, lcd_rs, lcd_e, in_ready, init_done} !== 8'h00) begin
         miscompares++;
         $display("FAIL midreset_outputs: got %h, required 00", {lcd_data, lcd_rs, lcd_e, in_ready, init_done});
      end
      trace.delete();
      reset = 1'b0;
      waitInitDone(ok);
      waitCycles(5);
      extractTrace();
      vectors++;
      if (strobes.size() != 4) begin
         miscompares++;
         $display("FAIL midreset_strobe_count: got %0d, required 4", strobes.size());
      end
      for (int k = 0; k < 4 && k < strobes.size(); k++) begin
         vectors++;
         if (strobes[k].d !== nib[k] || strobes[k].rs !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_nib%0d: got d=%h rs=%b, required d=%h rs=0", k, strobes[k].d, strobes[k].rs, nib[k]);
         end
      end
      expDone = T_POWERON + 4 * N + T_INIT + 3 * T_CMD;
      vectors++;
      if (readyRises.size() < 1 || readyRises[0] != expDone) begin
         miscompares++;
         $display("FAIL midreset_ready: got %0d, required %0d", readyRises.size() > 0 ? readyRises[0] : -1, expDone);
      end
   endtask

   task automatic test_ignore_busy();
      bit ok;
      int acc;
      int acc2;
      int callCyc;
      trace.delete();
      sendByte(8'h41, 1'b1, acc, ok);
      waitCycles(2 * N + 2);
      in_data  = 8'h7E;
      in_rs    = 1'b0;
      in_valid = 1'b1;
      @(negedge refclk);
      in_valid = 1'b0;
      waitReady(ok);
      waitCycles(5);
      extractTrace();
      vectors++;
      if (strobes.size() != 2 || strobes[0].d !== 4'h4 || strobes[1].d !== 4'h1) begin
         miscompares++;
         $display("FAIL busy_ignored: got %0d strobes first=%h, required 2 strobes 4/1",
                  strobes.size(), strobes.size() > 0 ? strobes[0].d : 4'hx);
      end
      vectors++;
      if (readyRises.size() != 1 || readyRises[0] != acc + 1 + 2 * N + T_CMD) begin
         miscompares++;
         $display("FAIL busy_ready: got %0d rises first=%0d, required 1 rise at %0d",
                  readyRises.size(), readyRises.size() > 0 ? readyRises[0] : -1, acc + 1 + 2 * N + T_CMD);
      end
      callCyc = edgeCount - 1;
      sendByte(8'h7E, 1'b0, acc2, ok);
      waitReady(ok);
      waitCycles(3);
      extractTrace();
      vectors++;
      if (acc2 != callCyc) begin
         miscompares++;
         $display("FAIL busy_late_accept: got %0d, required %0d", acc2, callCyc);
      end
      vectors++;
      if (strobes.size() != 4 || strobes[2].d !== 4'h7 || strobes[3].d !== 4'hE ||
          strobes[2].rs !== 1'b0 || strobes[2].c != acc2 + 1 + T_SETUP) begin
         miscompares++;
         $display("FAIL busy_late_byte: got %0d strobes d=%h/%h rise=%0d, required 4 strobes 7/E rise=%0d",
                  strobes.size(), strobes.size() > 2 ? strobes[2].d : 4'hx,
                  strobes.size() > 3 ? strobes[3].d : 4'hx, strobes.size() > 2 ? strobes[2].c : -1,
                  acc2 + 1 + T_SETUP);
      end
   endtask

   // Run the scenarios in order. Each one leaves the DUT idle with in_ready high.
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      in_rs       = 1'b0;
      @(negedge refclk);
      test_reset();
      test_data_byte();
      test_clear_cmd();
      test_back_to_back();
      test_reset_mid();
      test_ignore_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
